// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte
// requesters. A winner's byte is latched and presented to the UART with
// tx_start until the UART reports busy (or done). The arbiter then waits
// for tx_done. A watchdog aborts a frame the UART never acknowledges or
// never completes, so the shared port cannot lock up.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    output logic [NREQ-1:0]           grant,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic                      arb_busy,
    output logic [$clog2(NREQ)-1:0]   active_id,
    output logic                      timeout_err
);

    localparam int ID_W = $clog2(NREQ);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] GNT_ONE  = NREQ'(1);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [WD_W-1:0]   wdog;

    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   cand_id;
    int                cand;

    // Round-robin search: first pending request after last_grant, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = 0;
        cand_id    = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand    = (int'(last_grant) + off) % NREQ;
            cand_id = ID_W'(cand);
            if (!pick_valid && req[cand_id]) begin
                pick_valid = 1'b1;
                pick_id    = cand_id;
            end else begin
                pick_valid = pick_valid;
            end
        end
    end

    // Arbitration/sequencing FSM with registered outputs and watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_grant  <= LAST_RST;
            wdog        <= '0;
            grant       <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            arb_busy    <= 1'b0;
            active_id   <= '0;
            timeout_err <= 1'b0;
        end else begin
            // grant and timeout_err are single-cycle pulses
            grant       <= '0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wdog <= '0;
                    if (pick_valid) begin
                        grant      <= GNT_ONE << pick_id;
                        tx_data    <= req_data[pick_id*DATA_W +: DATA_W];
                        active_id  <= pick_id;
                        last_grant <= pick_id;
                        tx_start   <= 1'b1;
                        arb_busy   <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A done without a seen busy still counts as acknowledge
                    if (tx_busy || tx_done) begin
                        tx_start <= 1'b0;
                        wdog     <= '0;
                        state    <= ST_WAIT;
                    end else if (wdog == WD_MAX) begin
                        tx_start    <= 1'b0;
                        timeout_err <= 1'b1;
                        arb_busy    <= 1'b0;
                        wdog        <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        arb_busy <= 1'b0;
                        wdog     <= '0;
                        state    <= ST_IDLE;
                    end else if (wdog == WD_MAX) begin
                        timeout_err <= 1'b1;
                        arb_busy    <= 1'b0;
                        wdog        <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    arb_busy <= 1'b0;
                    wdog     <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=4, TIMEOUT=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic        arb_busy;
    logic [1:0]  active_id;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.NREQ(4), .DATA_W(8), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .arb_busy    (arb_busy),
        .active_id   (active_id),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        checks++;
        if (obs !== exp_val) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_val);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        req     = 4'b0000;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait for a grant, check it, then run one well-behaved UART frame.
    task automatic frame(input int id, input logic [7:0] byte_exp,
                         input logic [3:0] clr, input logic [3:0] set);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == 4'b0000 && n < 8);
        chk("grant", 32'(grant), 32'd1 << id);
        chk("active_id", 32'(active_id), 32'(id));
        chk("tx_data", 32'(tx_data), 32'(byte_exp));
        chk("tx_start_on", 32'(tx_start), 32'd1);
        chk("arb_busy_on", 32'(arb_busy), 32'd1);
        req = (req & ~clr) | set;
        @(negedge clk);
        chk("grant_pulse", 32'(grant), 32'd0);
        chk("tx_start_hold", 32'(tx_start), 32'd1);
        chk("tx_data_hold", 32'(tx_data), 32'(byte_exp));
        tx_busy = 1'b1;
        @(negedge clk);
        chk("tx_start_off", 32'(tx_start), 32'd0);
        chk("arb_busy_wait", 32'(arb_busy), 32'd1);
        tx_busy = 1'b0;
        repeat (2) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        chk("arb_busy_done", 32'(arb_busy), 32'd0);
        chk("tx_data_keep", 32'(tx_data), 32'(byte_exp));
        tx_done = 1'b0;
    endtask

    initial begin
        int n;
        int cnt;
        rst      = 1'b1;
        req      = 4'b0000;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
        req_data = {8'hA3, 8'hC2, 8'h5A, 8'hDB};
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_arb_busy", 32'(arb_busy), 32'd0);
        chk("rst_active_id", 32'(active_id), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single request
        do_reset();
        req = 4'b0001;
        frame(0, 8'hDB, 4'b0001, 4'b0000);
        @(negedge clk);
        chk("single_idle_grant", 32'(grant), 32'd0);

        // All-request fairness: 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        frame(0, 8'hDB, 4'b0000, 4'b0000);
        frame(1, 8'h5A, 4'b0000, 4'b0000);
        frame(2, 8'hC2, 4'b0000, 4'b0000);
        frame(3, 8'hA3, 4'b0000, 4'b0000);
        frame(0, 8'hDB, 4'b1111, 4'b0000);

        // Late joiners: 2, then 1 joins -> 1, 2, then 3 joins -> 3, 1
        do_reset();
        req = 4'b0100;
        frame(2, 8'hC2, 4'b0000, 4'b0010);
        frame(1, 8'h5A, 4'b0000, 4'b0000);
        frame(2, 8'hC2, 4'b0000, 4'b1000);
        frame(3, 8'hA3, 4'b1000, 4'b0000);
        frame(1, 8'h5A, 4'b1111, 4'b0000);

        // Stuck UART: watchdog abort after 16 cycles, then next request served
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        chk("stuck_grant", 32'(grant), 32'd1);
        req = 4'b0100;
        n = 0;
        while (tx_start === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("stuck_start_cycles", 32'(n), 32'd16);
        chk("stuck_timeout_err", 32'(timeout_err), 32'd1);
        chk("stuck_arb_busy", 32'(arb_busy), 32'd0);
        chk("stuck_no_grant", 32'(grant), 32'd0);
        frame(2, 8'hC2, 4'b0100, 4'b0000);

        // Reset during WAIT, then arbitration restarts from requester 0
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        chk("rw_grant", 32'(grant), 32'd2);
        req = 4'b0000;
        @(negedge clk);
        tx_busy = 1'b1;
        @(negedge clk);
        chk("rw_in_wait", 32'(arb_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rw_tx_start", 32'(tx_start), 32'd0);
        chk("rw_grant_rst", 32'(grant), 32'd0);
        chk("rw_arb_busy", 32'(arb_busy), 32'd0);
        chk("rw_tx_data", 32'(tx_data), 32'd0);
        chk("rw_active_id", 32'(active_id), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        tx_busy = 1'b0;
        req     = 4'b0101;
        frame(0, 8'hDB, 4'b0101, 4'b0000);

        // Simultaneous tx_busy and tx_done in ISSUE
        do_reset();
        req = 4'b1000;
        @(negedge clk);
        chk("sim_grant", 32'(grant), 32'd8);
        chk("sim_tx_data", 32'(tx_data), 32'hA3);
        req     = 4'b0000;
        tx_busy = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        chk("sim_tx_start_off", 32'(tx_start), 32'd0);
        chk("sim_in_wait", 32'(arb_busy), 32'd1);
        tx_busy = 1'b0;
        tx_done = 1'b0;
        @(negedge clk);
        chk("sim_still_wait", 32'(arb_busy), 32'd1);
        tx_done = 1'b1;
        @(negedge clk);
        chk("sim_idle", 32'(arb_busy), 32'd0);
        tx_done = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (grant != 4'b0000 || tx_start) cnt++;
        end
        chk("sim_no_reissue", 32'(cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among NREQ byte requesters. It sits between the requesting blocks and the UART TX port. It selects a requester, drives tx_start/tx_data, holds them until the UART reports busy, then waits for tx_done before serving the next request. A watchdog recovers the arbiter if the UART never acknowledges or never completes.

## Interface
- NREQ, 4: number of requesters, 2..8
- DATA_W, 8: byte width, matches UART tx_data
- TIMEOUT, 4096: max cycles allowed in ISSUE or WAIT before abort, ≥ 2
- clk  input  1  system clock, rising-edge
- rst  input  1  reset, asynchronous and active-high
- req  input  NREQ  per-requester request level; held high until grant
- req_data  input  NREQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]; stable while req[i] high
- grant  output  NREQ  one-hot one-cycle pulse: request i accepted, byte captured
- tx_start  output  1  to UART; start transmission
- tx_data  output  DATA_W  to UART; registered byte
- tx_busy  input  1  from UART; frame in progress
- tx_done  input  1  from UART; frame complete pulse/level
- arb_busy  output  1  high whenever state ≠ IDLE
- active_id  output  $clog2(NREQ)  index of requester currently served
- timeout_err  output  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any req bit is high, pick the winner by round-robin. The search starts at last_grant+1 mod NREQ and takes the first set bit. Register tx_data ← req_data[winner], active_id ← winner, last_grant ← winner. Pulse grant[winner], set tx_start=1, go to ISSUE. With no request, stay in IDLE.
- ISSUE: hold tx_start=1 and tx_data stable.
  - On tx_busy=1 or tx_done=1: tx_start ← 0, go to WAIT.
- WAIT: tx_start=0. On tx_done=1, go to IDLE.
- Watchdog: a counter clears on every state entry and increments each cycle in ISSUE/WAIT. When it reaches TIMEOUT-1 without the exit condition: pulse timeout_err, tx_start ← 0, go to IDLE. The byte is dropped, not retried, and last_grant is unchanged.
- last_grant reset value is NREQ-1, so requester 0 wins the first arbitration.
- A requester that is still high after its grant is re-arbitrated as a new request. Round-robin guarantees every other pending requester is served first.
- req bits change only arbitration in IDLE. Deasserting req during ISSUE/WAIT has no effect.
- tx_data holds its last value after completion; it is only updated on grant.
- Simultaneous tx_busy and tx_done in ISSUE: go to WAIT. The next cycle sees tx_done only if it is still high.
- If tx_done is held as a level, the arbiter returns to IDLE once and can accept a new grant the following cycle. The UART must drop tx_done before re-asserting tx_busy for the new frame.

## Timing
- Reset (async, immediate): state=IDLE, tx_start=0, tx_data=0, grant=0, arb_busy=0, active_id=0, timeout_err=0, last_grant=NREQ-1, watchdog=0.
- All outputs are registered; no combinational path from inputs to outputs.
- req high in cycle N (in IDLE) → grant pulse, tx_start=1 and tx_data valid in cycle N+1.
- tx_busy high in cycle M (ISSUE) → tx_start=0 in cycle M+1.
- tx_done high in cycle K (WAIT) → arb_busy=0 in cycle K+1. The earliest next grant is cycle K+2.
- Watchdog abort: timeout_err pulse and IDLE exactly TIMEOUT cycles after state entry.
- Reset mid-frame: all outputs are forced to their reset values asynchronously. The UART frame in flight is not tracked.

## Test plan
- Single request: req=4'b0001, req_data[7:0]=8'hDB.
  - grant=4'b0001 pulse one cycle after req.
  - tx_start=1 with tx_data=8'hDB held until tx_busy.
  - arb_busy drops one cycle after tx_done.
- All-request fairness: req=4'b1111 held, UART model completes each frame in 20 cycles.
  - Grant order 0,1,2,3,0 with active_id matching.
  - No requester is served twice before all others.
- Late joiner: requester 2 active, requester 1 asserts mid-frame.
  - After tx_done the next grant goes to 3 if it is pending, else 1.
  - Never 2 again before the others.
- Stuck UART: with TIMEOUT=16, tx_busy and tx_done are held 0 after grant.
  - tx_start stays high for 16 cycles.
  - timeout_err pulses, state returns to IDLE.
  - The next pending request is granted normally.
- Reset mid-WAIT: assert rst during a frame.
  - tx_start=0, grant=0, arb_busy=0 immediately.
  - After release with req=4'b0100, the first grant is 4'b0100 (last_grant restored to NREQ-1).
- Simultaneous tx_busy and tx_done in ISSUE: one pulse of each.
  - The arbiter passes through WAIT and returns to IDLE.
  - Exactly one grant for the byte; no double issue.
